// File: rtl/ongorucu_bht.sv
`default_nettype none
// ============================================================================
//  Module   : ongorucu_bht
//  Purpose  : Fetch-stage dynamic branch predictor: 2-bit counter BHT plus a
//             direct-mapped BTB; JAL predicted taken from its immediate.
//             Optional gshare indexing enabled by ONGORUCU_GSHARE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module ongorucu_bht #(
    parameter int BHT_GIRIS = 64,
    parameter int BTB_GIRIS = 32,
    parameter int GHR_BIT   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] getir_ps,
    input  logic [31:0] getir_buyruk,
    input  logic        getir_gecerli,
    input  logic [31:0] yurut_ps,
    input  logic [31:0] yurut_buyruk,
    input  logic        yurut_dallan,
    input  logic [31:0] yurut_dallan_ps,
    input  logic        yurut_gecerli,
    output logic        sonuc_dallan,
    output logic [31:0] sonuc_dallan_ps
);

    localparam int         c_BHT_W  = $clog2(BHT_GIRIS);
    localparam int         c_BTB_W  = $clog2(BTB_GIRIS);
    localparam int         c_TAG_W  = 30 - c_BTB_W;
    localparam logic [6:0] c_OP_B   = 7'b1100011;
    localparam logic [6:0] c_OP_JAL = 7'b1101111;

    if (BHT_GIRIS < 4 || BHT_GIRIS > 1024 || (BHT_GIRIS & (BHT_GIRIS - 1)) != 0 ||
        BTB_GIRIS < 4 || BTB_GIRIS > BHT_GIRIS || (BTB_GIRIS & (BTB_GIRIS - 1)) != 0 ||
        GHR_BIT < 1 || GHR_BIT > c_BHT_W) begin : g_param_err
        $error("ongorucu_bht: illegal parameter combination");
    end

    logic [1:0]         r_bht        [BHT_GIRIS];
    logic               r_btb_valid  [BTB_GIRIS];
    logic [c_TAG_W-1:0] r_btb_tag    [BTB_GIRIS];
    logic [31:0]        r_btb_target [BTB_GIRIS];

    logic               w_get_b;
    logic               w_get_jal;
    logic [31:0]        w_get_jimm;
    logic [c_BHT_W-1:0] w_get_bht_idx;
    logic [c_BTB_W-1:0] w_get_btb_idx;
    logic               w_get_hit;

    logic               w_upd;
    logic [c_BHT_W-1:0] w_yur_bht_idx;
    logic [c_BTB_W-1:0] w_yur_btb_idx;
    logic [1:0]         w_ctr_old;
    logic [1:0]         w_ctr_new;

    logic               w_unused;

    assign w_get_b    = (getir_buyruk[6:0] == c_OP_B);
    assign w_get_jal  = (getir_buyruk[6:0] == c_OP_JAL);
    assign w_get_jimm = {{11{getir_buyruk[31]}}, getir_buyruk[31], getir_buyruk[19:12],
                         getir_buyruk[20], getir_buyruk[30:21], 1'b0};

    assign w_upd = yurut_gecerli && (yurut_buyruk[6:0] == c_OP_B);

`ifdef ONGORUCU_GSHARE_EN
    // Non-speculative history: advanced only by resolved branches from execute.
    logic [GHR_BIT-1:0] r_ghr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (w_upd) begin
            r_ghr <= GHR_BIT'({r_ghr, yurut_dallan});
        end
    end

    assign w_get_bht_idx = getir_ps[c_BHT_W+1:2] ^ c_BHT_W'(r_ghr);
    assign w_yur_bht_idx = yurut_ps[c_BHT_W+1:2] ^ c_BHT_W'(r_ghr);
`else
    assign w_get_bht_idx = getir_ps[c_BHT_W+1:2];
    assign w_yur_bht_idx = yurut_ps[c_BHT_W+1:2];
`endif

    assign w_get_btb_idx = getir_ps[c_BTB_W+1:2];
    assign w_yur_btb_idx = yurut_ps[c_BTB_W+1:2];

    assign w_get_hit = r_btb_valid[w_get_btb_idx] &&
                       (r_btb_tag[w_get_btb_idx] == getir_ps[31:c_BTB_W+2]);

    always_comb begin
        sonuc_dallan    = 1'b0;
        sonuc_dallan_ps = getir_ps + 32'd4;
        if (getir_gecerli) begin
            if (w_get_jal) begin
                sonuc_dallan    = 1'b1;
                sonuc_dallan_ps = getir_ps + w_get_jimm;
            end else if (w_get_b && r_bht[w_get_bht_idx][1] && w_get_hit) begin
                sonuc_dallan    = 1'b1;
                sonuc_dallan_ps = r_btb_target[w_get_btb_idx];
            end
        end
    end

    assign w_ctr_old = r_bht[w_yur_bht_idx];

    always_comb begin
        w_ctr_new = w_ctr_old;
        if (yurut_dallan) begin
            if (w_ctr_old != 2'b11) w_ctr_new = w_ctr_old + 2'b01;
        end else begin
            if (w_ctr_old != 2'b00) w_ctr_new = w_ctr_old - 2'b01;
        end
    end

    // Reset has priority over a concurrent update, so the update is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_GIRIS; i++) r_bht[i] <= 2'b01;
            for (int i = 0; i < BTB_GIRIS; i++) begin
                r_btb_valid[i]  <= 1'b0;
                r_btb_tag[i]    <= '0;
                r_btb_target[i] <= '0;
            end
        end else if (w_upd) begin
            r_bht[w_yur_bht_idx] <= w_ctr_new;
            if (yurut_dallan) begin
                r_btb_valid[w_yur_btb_idx]  <= 1'b1;
                r_btb_tag[w_yur_btb_idx]    <= yurut_ps[31:c_BTB_W+2];
                r_btb_target[w_yur_btb_idx] <= yurut_dallan_ps;
            end
        end
    end

    assign w_unused = ^{getir_buyruk[11:7], yurut_buyruk[31:7], yurut_ps[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_ongorucu_bht.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ongorucu_bht
//  Purpose  : Directed, table-driven self-checking bench for ongorucu_bht.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ongorucu_bht;

    localparam logic [31:0] c_B   = 32'h0000_0063;
    localparam logic [31:0] c_NB  = 32'h0000_0013;
    localparam logic [31:0] c_JAL = 32'hFF1F_F06F;   // jal x0, -16

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] getir_ps, getir_buyruk;
    logic        getir_gecerli;
    logic [31:0] yurut_ps, yurut_buyruk, yurut_dallan_ps;
    logic        yurut_dallan, yurut_gecerli;
    logic        sonuc_dallan;
    logic [31:0] sonuc_dallan_ps;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    ongorucu_bht #(.BHT_GIRIS(64), .BTB_GIRIS(32), .GHR_BIT(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .getir_ps        (getir_ps),
        .getir_buyruk    (getir_buyruk),
        .getir_gecerli   (getir_gecerli),
        .yurut_ps        (yurut_ps),
        .yurut_buyruk    (yurut_buyruk),
        .yurut_dallan    (yurut_dallan),
        .yurut_dallan_ps (yurut_dallan_ps),
        .yurut_gecerli   (yurut_gecerli),
        .sonuc_dallan    (sonuc_dallan),
        .sonuc_dallan_ps (sonuc_dallan_ps)
    );

    typedef struct {
        string       name;
        logic        uv;
        logic [31:0] ups;
        logic [31:0] uins;
        logic        ut;
        logic [31:0] utgt;
        logic        fv;
        logic [31:0] fps;
        logic [31:0] fins;
        logic        et;
        logic [31:0] eps;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic uv, logic [31:0] ups, logic [31:0] uins,
                                logic ut, logic [31:0] utgt, logic fv, logic [31:0] fps,
                                logic [31:0] fins, logic et, logic [31:0] eps);
        vec_t v;
        v.name = name; v.uv = uv; v.ups = ups; v.uins = uins; v.ut = ut; v.utgt = utgt;
        v.fv = fv; v.fps = fps; v.fins = fins; v.et = et; v.eps = eps;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        yurut_gecerli   = v.uv;
        yurut_ps        = v.ups;
        yurut_buyruk    = v.uins;
        yurut_dallan    = v.ut;
        yurut_dallan_ps = v.utgt;
        getir_gecerli   = v.fv;
        getir_ps        = v.fps;
        getir_buyruk    = v.fins;
    endtask

    task automatic check(input string name, input logic et, input logic [31:0] eps);
        n_total++;
        if (sonuc_dallan === et && sonuc_dallan_ps === eps) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got dallan=%b ps=%08h, expected dallan=%b ps=%08h",
                     name, sonuc_dallan, sonuc_dallan_ps, et, eps);
        end
    endtask

    // Drive during the cycle, check at the falling edge (before the update lands).
    task automatic step(input vec_t v);
        drive(v);
        @(negedge clk);
        check(v.name, v.et, v.eps);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        do_reset();

`ifndef ONGORUCU_GSHARE_EN
        //          name            uv ups           uins   ut utgt          fv fps           fins   et eps
        vecs.push_back(mk("reset_b100",    0, 0,        0,     0, 0,        1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("gecerli0",      0, 0,        0,     0, 0,        0, 32'h200,  c_JAL, 0, 32'h204));
        vecs.push_back(mk("jal_untrained", 0, 0,        0,     0, 0,        1, 32'h200,  c_JAL, 1, 32'h1F0));
        vecs.push_back(mk("same_cyc_old",  1, 32'h100,  c_B,   1, 32'h80,   1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("trained_t",     0, 0,        0,     0, 0,        1, 32'h100,  c_B,   1, 32'h80));
        vecs.push_back(mk("alias_btb",     0, 0,        0,     0, 0,        1, 32'h180,  c_B,   0, 32'h184));
        vecs.push_back(mk("alias_tag",     0, 0,        0,     0, 0,        1, 32'h200,  c_B,   0, 32'h204));
        vecs.push_back(mk("nt1_old",       1, 32'h100,  c_B,   0, 0,        1, 32'h100,  c_B,   1, 32'h80));
        vecs.push_back(mk("nt2_old",       1, 32'h100,  c_B,   0, 0,        1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("after_2nt",     0, 0,        0,     0, 0,        1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("jal_in_exec",   1, 32'h100,  c_JAL, 1, 32'h300,  1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("nb_in_exec",    1, 32'h100,  c_NB,  1, 32'h300,  1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("t_from_00",     1, 32'h100,  c_B,   1, 32'h80,   1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("exec_noupd",    0, 0,        0,     0, 0,        1, 32'h100,  c_B,   0, 32'h104));
        vecs.push_back(mk("sat_t1",        1, 32'h40,   c_B,   1, 32'h500,  1, 32'h40,   c_B,   0, 32'h44));
        vecs.push_back(mk("sat_t2",        1, 32'h40,   c_B,   1, 32'h500,  1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_t3",        1, 32'h40,   c_B,   1, 32'h500,  1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_t4",        1, 32'h40,   c_B,   1, 32'h500,  1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_t5",        1, 32'h40,   c_B,   1, 32'h500,  1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_nt",        1, 32'h40,   c_B,   0, 0,        1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_still_t",   1, 32'h40,   c_B,   0, 0,        1, 32'h40,   c_B,   1, 32'h500));
        vecs.push_back(mk("sat_now_wnt",   0, 0,        0,     0, 0,        1, 32'h40,   c_B,   0, 32'h44));
        vecs.push_back(mk("wrap_nb",       0, 0,        0,     0, 0,        1, 32'hFFFF_FFFC, c_NB, 0, 32'h0));
        vecs.push_back(mk("btb_overwrite", 1, 32'h180,  c_B,   1, 32'h900,  1, 32'h180,  c_B,   0, 32'h184));
        vecs.push_back(mk("ovw_pred",      0, 0,        0,     0, 0,        1, 32'h180,  c_B,   1, 32'h900));

        foreach (vecs[i]) step(vecs[i]);

        // Reset coinciding with a taken update at 0x40: the update must be dropped.
        drive(mk("rst_upd", 1, 32'h40, c_B, 1, 32'h500, 0, 0, 0, 0, 0));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(mk("rst_drops_upd", 0, 0, 0, 0, 0, 1, 32'h40,  c_B, 0, 32'h44));
        step(mk("rst_clears_btb", 0, 0, 0, 0, 0, 1, 32'h180, c_B, 0, 32'h184));
`else
        step(mk("reset_b100",    0, 0, 0, 0, 0, 1, 32'h100, c_B,   0, 32'h104));
        step(mk("jal_untrained", 0, 0, 0, 0, 0, 1, 32'h200, c_JAL, 1, 32'h1F0));
        // Alternating T/N at 0x100; after warm-up every prediction must match the outcome.
        for (int k = 0; k < 20; k++) begin
            logic t;
            t = (k % 2 == 0);
            drive(mk("alt", 1, 32'h100, c_B, t, 32'h80, 1, 32'h100, c_B, 0, 0));
            @(negedge clk);
            if (k >= 12) check($sformatf("gshare_alt_%0d", k), t, t ? 32'h80 : 32'h104);
            @(posedge clk);
            #1;
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ongorucu_bht.md
Name: ongorucu_bht

Overview:
Parametrised dynamic branch predictor for the fetch stage (getir), replacing the fixed always-taken/constant-target predictor.
- Predicts conditional branches with a table of 2-bit saturating counters (BHT) plus a direct-mapped branch target buffer (BTB).
- Predicts JAL as always taken, target computed from its immediate.
- Tables are trained from resolved branches reported by the execute stage (yurut).

Parameters:
- BHT_GIRIS, 64: number of 2-bit counters; power of two, 4..1024.
- BTB_GIRIS, 32: number of BTB entries; power of two, 4..BHT_GIRIS.
- GHR_BIT, 6: global history length; used only with GSHARE_EN; 1..log2(BHT_GIRIS).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- getir_ps  input  32  PC of instruction in fetch.
- getir_buyruk  input  32  instruction word in fetch.
- getir_gecerli  input  1  fetch slot valid.
- yurut_ps  input  32  PC of instruction in execute.
- yurut_buyruk  input  32  instruction word in execute.
- yurut_dallan  input  1  resolved outcome: 1 = taken.
- yurut_dallan_ps  input  32  resolved taken target.
- yurut_gecerli  input  1  execute slot valid.
- sonuc_dallan  output  1  prediction: redirect fetch.
- sonuc_dallan_ps  output  32  predicted next PC.

Behaviour:
- Single clock domain, clk. Reset is synchronous and active-high on rst.
- Decode, applied to both getir_buyruk and yurut_buyruk:
  - B-type: opcode[6:0] = 7'b1100011.
  - JAL: opcode[6:0] = 7'b1101111.
  - All other opcodes are non-branch.
- Indices, taken from ps[1:0] upward at bit 2:
  - BHT index: ps[log2(BHT_GIRIS)+1:2].
  - BTB index: ps[log2(BTB_GIRIS)+1:2].
  - BTB tag: ps[31:log2(BTB_GIRIS)+2].
- Prediction path (combinational from getir_* and current table state; zero latency):
  - getir_gecerli = 0: sonuc_dallan = 0.
  - JAL: sonuc_dallan = 1; sonuc_dallan_ps = getir_ps + sign-extended J-immediate, wrapping mod 2^32.
  - B-type: sonuc_dallan = counter[1] AND btb_valid AND tag match; sonuc_dallan_ps = BTB target.
  - Whenever sonuc_dallan = 0: sonuc_dallan_ps = getir_ps + 4, wrapping mod 2^32 (0xFFFFFFFC -> 0x00000000).
- Update path (registered; effective at the next rising clk edge):
  - Trigger: yurut_gecerli = 1 AND yurut_buyruk is B-type.
  - Counter: yurut_dallan = 1 -> increment, saturating at 2'b11; yurut_dallan = 0 -> decrement, saturating at 2'b00.
  - BTB: when yurut_dallan = 1, write valid = 1, tag, target = yurut_dallan_ps into the BTB entry; this overwrites any aliasing entry.
  - BTB on not-taken: entry left unchanged.
  - JAL and non-branch instructions in execute: no table update.
- Simultaneous read and update of the same index: the prediction sees the pre-update (old) value. Read-before-write; no bypass.
- Reset: all counters = 2'b01 (weakly not-taken), all BTB valid = 0, GHR = 0.
  - Outputs follow from the combinational prediction rules. With getir_gecerli = 0, sonuc_dallan = 0 and sonuc_dallan_ps = getir_ps + 4.
  - rst asserted together with an update: reset wins; the update is dropped.
- Counter states: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken. Predict taken iff bit 1 = 1.

Optional Feature:
- Macro: ONGORUCU_GSHARE_EN.
- Defined:
  - A GHR_BIT-wide global history register shifts in yurut_dallan (LSB side) on every update event.
  - BHT index = PC index XOR zero-extended GHR.
  - Prediction uses the current GHR; update uses the GHR value before its shift in that cycle.
  - History is non-speculative; index mismatch between predict and update is accepted.
  - BTB indexing is unaffected.
- Undefined: no GHR register exists; BHT index is the PC index only.

Test Plan:
- Reset: rst=1 for 2 cycles, then B-type at getir_ps=0x100 -> sonuc_dallan=0, sonuc_dallan_ps=0x104.
- Training: one taken update of B-type at 0x100 to 0x80 -> counter 10, BTB valid. Next fetch at 0x100 -> sonuc_dallan=1, sonuc_dallan_ps=0x80. Two not-taken updates -> counter 00, sonuc_dallan=0.
- Saturation: 5 taken updates then 1 not-taken at 0x40 -> counter 10, still predicts taken. Fifth consecutive taken update leaves counter at 11.
- JAL at getir_ps=0x200 with imm=-16 -> sonuc_dallan=1, sonuc_dallan_ps=0x1F0, with no prior training. JAL in execute -> tables unchanged.
- Aliasing/tag: train 0x100 taken; fetch 0x100+4*BTB_GIRIS -> tag mismatch, sonuc_dallan=0. Same-cycle update and fetch of 0x100 -> old prediction this cycle, new prediction next cycle.
- Edge cases: wrap at getir_ps=0xFFFFFFFC, non-branch -> sonuc_dallan_ps=0x00000000. With ONGORUCU_GSHARE_EN, alternating T/N pattern at one PC -> correct prediction after warm-up of ≤ 2*GHR_BIT updates.
